// File: rtl/ram_distributed_lsu.sv
// Byte-addressed single-port LUT data memory for the MEM stage.
// Sub-word loads/stores, error reporting, registered response, zero-clear.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   req_valid/req_ready  request handshake (ready only when idle)
//   req_we               1 = store, 0 = load
//   req_funct3           RISC-V width/sign code (b,h,w,bu,hu)
//   req_addr             byte address, [1:0] lane, upper bits word
//   req_wdata            right-aligned store data
//   rsp_valid            pulse one cycle after an accept
//   rsp_rdata            extended load data, 0 for stores/errors
//   rsp_err              misaligned or illegal funct3, nothing written
//   busy                 zero-clear in progress
module ram_distributed_lsu #(
   parameter int ADDR_W         = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [31:0]       mem [DEPTH];

   logic [ADDR_W-1:0] widx;
   logic [1:0]        lane;
   logic              accept;
   logic              op_ok;
   logic              align_ok;
   logic              legal;
   logic [3:0]        st_be;
   logic [31:0]       st_data;
   logic [3:0]        wr_be;
   logic [ADDR_W-1:0] wr_idx;
   logic [31:0]       wr_data;
   logic [31:0]       rword;
   logic [31:0]       rshift;
   logic [31:0]       ld_data;

   assign widx   = req_addr[ADDR_W+1:2];
   assign lane   = req_addr[1:0];
   assign accept = req_valid & req_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_CLEAR)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      req_ready = 1'b0;
      unique case (state)
         S_CLEAR: begin
            busy = 1'b1;
            if (cnt == {ADDR_W{1'b1}})
               state_nx = S_IDLE;
         end
         S_IDLE: req_ready = 1'b1;
         default: state_nx = S_IDLE;
      endcase
   end

   // Unsigned variants exist only for loads.
   always_comb begin
      op_ok    = 1'b0;
      align_ok = 1'b0;
      case (req_funct3)
         3'b000: begin op_ok = 1'b1;    align_ok = 1'b1;       end
         3'b001: begin op_ok = 1'b1;    align_ok = ~lane[0];   end
         3'b010: begin op_ok = 1'b1;    align_ok = (lane == 2'd0); end
         3'b100: begin op_ok = ~req_we; align_ok = 1'b1;       end
         3'b101: begin op_ok = ~req_we; align_ok = ~lane[0];   end
         default: ;
      endcase
      legal = op_ok & align_ok;
   end

   // Replicate store data so each lane sees its right-aligned slice.
   always_comb begin
      st_be   = 4'b1111;
      st_data = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            st_be   = 4'b0001 << lane;
            st_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            st_be   = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // The clear sequencer owns the single write port while busy.
   always_comb begin
      wr_be   = 4'b0000;
      wr_idx  = widx;
      wr_data = st_data;
      if (busy) begin
         wr_be   = 4'b1111;
         wr_idx  = cnt;
         wr_data = 32'h0;
      end else if (accept & req_we & legal) begin
         wr_be = st_be;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (wr_be[i])
            mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
   end

   // Halfword lanes are 0 or 2 when legal, so the shifted low half is right.
   assign rword  = mem[widx];
   assign rshift = rword >> {lane, 3'b000};

   always_comb begin
      ld_data = 32'h0;
      case (req_funct3)
         3'b000: ld_data = {{24{rshift[7]}}, rshift[7:0]};
         3'b001: ld_data = {{16{rshift[15]}}, rshift[15:0]};
         3'b010: ld_data = rword;
         3'b100: ld_data = {24'h0, rshift[7:0]};
         3'b101: ld_data = {16'h0, rshift[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= accept;
         if (accept) begin
            rsp_err   <= ~legal;
            rsp_rdata <= (legal & ~req_we) ? ld_data : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_ram_distributed_lsu.sv
// Randomised and directed bench for ram_distributed_lsu (ADDR_W=4).
// Reference is a flat byte array with RISC-V load/store rules.
module tb_ram_distributed_lsu;
   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mb [64];
   logic [31:0] last_rd;
   logic        last_err;

   ram_distributed_lsu #(.ADDR_W(4), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int i = 0; i < 64; i++) mb[i] = 8'h0;
   endfunction

   function automatic void model_access(
      input logic we, input logic [2:0] f3, input logic [5:0] a,
      input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int     size;
      bit     ok;
      longint v;
      size = 1 << f3[1:0];
      ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
           && (int'(a) % size == 0) && !(we && f3[2]);
      err = !ok;
      rd  = 32'h0;
      if (ok && we) begin
         for (int k = 0; k < size; k++)
            mb[(int'(a) + k) % 64] = wd[8*k +: 8];
      end else if (ok) begin
         v = 0;
         for (int k = 0; k < size; k++)
            v = v | (longint'(mb[int'(a) + k]) << (8 * k));
         if (!f3[2] && v[8*size-1])
            v = v - (64'sd1 <<< (8 * size));
         rd = v[31:0];
      end
   endfunction

   // Presents one request for one edge; returns model and observed response.
   task automatic do_req(
      input logic we, input logic [2:0] f3, input logic [5:0] a,
      input logic [31:0] wd, output logic rdy,
      output logic e_err, output logic [31:0] e_rd,
      output logic g_v, output logic g_err, output logic [31:0] g_rd);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      rdy = req_ready;
      model_access(we, f3, a, wd, e_err, e_rd);
      @(posedge clk); #1;
      g_v = rsp_valid; g_err = rsp_err; g_rd = rsp_rdata;
      last_rd = e_rd; last_err = e_err;
   endtask

   task automatic idle(output logic g_v, output logic g_err,
                       output logic [31:0] g_rd);
      req_valid = 1'b0;
      @(posedge clk); #1;
      g_v = rsp_valid; g_err = rsp_err; g_rd = rsp_rdata;
   endtask

   // Counts busy cycles while hammering the port with a store.
   task automatic run_clear(output int cycles, output int viol);
      cycles = 0; viol = 0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 6'h0; req_wdata = 32'hFFFF_FFFF;
      while (busy === 1'b1 && cycles < 100) begin
         if (req_ready !== 1'b0 || rsp_valid !== 1'b0) viol++;
         @(posedge clk); #1;
         cycles++;
      end
      req_valid = 1'b0;
      if (rsp_valid !== 1'b0) viol++;
      model_clear();
   endtask

   task automatic test_reset();
      int cyc, viol;
      rstn = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 6'h0; req_wdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0 0 0",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      n_cmp++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy: got busy=%b ready=%b want 1 0",
                  busy, req_ready);
      end
      rstn = 1'b1;
      run_clear(cyc, viol);
      n_cmp++;
      if (cyc != 16) begin
         n_bad++;
         $display("FAIL clear_len: got %0d want 16", cyc);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL clear_gate: got %0d violations want 0", viol);
      end
      last_rd = 32'h0; last_err = 1'b0;
   endtask

   task automatic test_clear_zero();
      logic rdy, ee, gv, ge;
      logic [31:0] er, gr;
      for (int w = 0; w < 16; w++) begin
         do_req(1'b0, 3'b010, 6'(w * 4), 32'h0, rdy, ee, er, gv, ge, gr);
         n_cmp++;
         if (!rdy || gv !== 1'b1 || ge !== 1'b0 || gr !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_w%0d: got r=%b v=%b e=%b d=%h want 1 1 0 0",
                     w, rdy, gv, ge, gr);
         end
      end
      idle(gv, ge, gr);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [5:0]  a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   task automatic test_subword();
      vec_t v[11];
      logic rdy, ee, gv, ge;
      logic [31:0] er, gr;
      v[0]  = '{1'b1, 3'b010, 6'h08, 32'h80FF7F01, 32'h0};
      v[1]  = '{1'b0, 3'b000, 6'h08, 32'h0, 32'h00000001};
      v[2]  = '{1'b0, 3'b000, 6'h09, 32'h0, 32'h0000007F};
      v[3]  = '{1'b0, 3'b000, 6'h0A, 32'h0, 32'hFFFFFFFF};
      v[4]  = '{1'b0, 3'b100, 6'h0A, 32'h0, 32'h000000FF};
      v[5]  = '{1'b0, 3'b001, 6'h0A, 32'h0, 32'hFFFF80FF};
      v[6]  = '{1'b0, 3'b101, 6'h0A, 32'h0, 32'h000080FF};
      v[7]  = '{1'b1, 3'b000, 6'h09, 32'h000000AB, 32'h0};
      v[8]  = '{1'b0, 3'b010, 6'h08, 32'h0, 32'h80FFAB01};
      v[9]  = '{1'b1, 3'b001, 6'h0A, 32'h00001234, 32'h0};
      v[10] = '{1'b0, 3'b010, 6'h08, 32'h0, 32'h1234AB01};
      for (int i = 0; i < 11; i++) begin
         do_req(v[i].we, v[i].f3, v[i].a, v[i].wd, rdy, ee, er, gv, ge, gr);
         n_cmp++;
         if (!rdy || gv !== 1'b1 || ge !== 1'b0 || gr !== v[i].exp) begin
            n_bad++;
            $display("FAIL subword_%0d: got r=%b v=%b e=%b d=%h want 1 1 0 %h",
                     i, rdy, gv, ge, gr, v[i].exp);
         end
      end
      idle(gv, ge, gr);
      n_cmp++;
      if (gv !== 1'b0 || gr !== last_rd || ge !== last_err) begin
         n_bad++;
         $display("FAIL subword_hold: got v=%b e=%b d=%h want 0 %b %h",
                  gv, ge, gr, last_err, last_rd);
      end
   endtask

   task automatic test_errors();
      vec_t v[6];
      logic rdy, ee, gv, ge;
      logic [31:0] er, gr;
      do_req(1'b1, 3'b010, 6'h00, 32'h13579BDF, rdy, ee, er, gv, ge, gr);
      v[0] = '{1'b0, 3'b010, 6'h06, 32'h0, 32'h0};
      v[1] = '{1'b0, 3'b001, 6'h03, 32'h0, 32'h0};
      v[2] = '{1'b1, 3'b010, 6'h02, 32'hDEADBEEF, 32'h0};
      v[3] = '{1'b0, 3'b011, 6'h00, 32'h0, 32'h0};
      v[4] = '{1'b1, 3'b100, 6'h00, 32'h000000FF, 32'h0};
      v[5] = '{1'b1, 3'b101, 6'h00, 32'h0000FFFF, 32'h0};
      for (int i = 0; i < 6; i++) begin
         do_req(v[i].we, v[i].f3, v[i].a, v[i].wd, rdy, ee, er, gv, ge, gr);
         n_cmp++;
         if (gv !== 1'b1 || ge !== 1'b1 || gr !== 32'h0) begin
            n_bad++;
            $display("FAIL err_%0d: got v=%b e=%b d=%h want 1 1 0",
                     i, gv, ge, gr);
         end
      end
      do_req(1'b0, 3'b010, 6'h00, 32'h0, rdy, ee, er, gv, ge, gr);
      n_cmp++;
      if (gv !== 1'b1 || ge !== 1'b0 || gr !== 32'h13579BDF) begin
         n_bad++;
         $display("FAIL err_nowrite: got v=%b e=%b d=%h want 1 0 13579bdf",
                  gv, ge, gr);
      end
      idle(gv, ge, gr);
   endtask

   task automatic test_back_to_back();
      logic rdy, ee, gv, ge;
      logic [31:0] er, gr, d;
      logic [5:0]  a;
      a = 6'($urandom_range(0, 15) * 4);
      d = 32'h0;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            d = $urandom;
            do_req(1'b1, 3'b010, a, d, rdy, ee, er, gv, ge, gr);
         end else begin
            do_req(1'b0, 3'b010, a, 32'h0, rdy, ee, er, gv, ge, gr);
         end
         n_cmp++;
         if (!rdy || gv !== 1'b1 || ge !== 1'b0
             || gr !== ((i % 2 == 1) ? d : 32'h0)) begin
            n_bad++;
            $display("FAIL b2b_%0d: got r=%b v=%b e=%b d=%h want 1 1 0 %h",
                     i, rdy, gv, ge, gr, (i % 2 == 1) ? d : 32'h0);
         end
      end
      idle(gv, ge, gr);
      n_cmp++;
      if (gv !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_end: got v=%b want 0", gv);
      end
   endtask

   task automatic test_random();
      logic rdy, ee, gv, ge;
      logic [31:0] er, gr;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle(gv, ge, gr);
            n_cmp++;
            if (gv !== 1'b0 || gr !== last_rd || ge !== last_err) begin
               n_bad++;
               $display("FAIL rand_idle_%0d: got v=%b e=%b d=%h want 0 %b %h",
                        i, gv, ge, gr, last_err, last_rd);
            end
         end else begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   6'($urandom_range(0, 63)), $urandom,
                   rdy, ee, er, gv, ge, gr);
            n_cmp++;
            if (!rdy || gv !== 1'b1 || ge !== ee || gr !== er) begin
               n_bad++;
               $display("FAIL rand_%0d: got r=%b v=%b e=%b d=%h want 1 1 %b %h",
                        i, rdy, gv, ge, gr, ee, er);
            end
         end
      end
      idle(gv, ge, gr);
   endtask

   task automatic test_mid_clear();
      int cyc, viol, early;
      early = 0;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      req_valid = 1'b1;
      repeat (7) begin
         if (busy !== 1'b1 || rsp_valid !== 1'b0) early++;
         @(posedge clk); #1;
      end
      rstn = 1'b0;
      @(posedge clk); #1;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) early++;
      rstn = 1'b1;
      n_cmp++;
      if (early != 0) begin
         n_bad++;
         $display("FAIL midclr_pre: got %0d violations want 0", early);
      end
      run_clear(cyc, viol);
      n_cmp++;
      if (cyc != 16 || viol != 0) begin
         n_bad++;
         $display("FAIL midclr_len: got %0d cycles %0d viol want 16 0",
                  cyc, viol);
      end
      last_rd = 32'h0; last_err = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 6'h0; req_wdata = 32'h0;
      last_rd = 32'h0; last_err = 1'b0;
      model_clear();
      test_reset();
      test_clear_zero();
      test_subword();
      test_errors();
      test_back_to_back();
      test_random();
      test_mid_clear();
      test_clear_zero();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_distributed_lsu.md
Name: ram_distributed_lsu

Overview:
- Parametrised successor to the word-only distributed data memory.
- Byte-addressed, single-port data memory for the core's MEM stage.
- Adds RISC-V sub-word loads/stores (byte/half/word, sign/zero extension), misalignment/illegal-op error reporting, a valid/ready request with a registered response, and an optional post-reset zero-clear sequencer.
- Array stays LUT (distributed) RAM: synchronous per-byte-lane write, asynchronous read.

Parameters:
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words of 32 bits.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = contents undefined/retained.

Ports:
- clk  input  1  clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  input  ADDR_W+2  byte address; [1:0] selects lane, [ADDR_W+1:2] selects word.
- req_wdata  input  32  store data, right-aligned (bits [7:0] for sb, [15:0] for sh).
- rsp_valid  output  1  one-cycle pulse: response for the request accepted on the previous edge.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or used an illegal funct3; no write performed.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (rstn=0, async): rsp_valid=0, rsp_rdata=0, rsp_err=0, clear counter=0. FSM -> CLEAR if CLEAR_ON_RESET, else IDLE. Array is never reset directly.
- Reset asserted mid-CLEAR restarts the clear at word 0.
- FSM CLEAR:
  - busy=1, req_ready=0.
  - Writes 32'h0 to word[cnt] each cycle, cnt+1.
  - After word DEPTH-1 is written, -> IDLE on the next edge. CLEAR lasts exactly DEPTH cycles.
- FSM IDLE: busy=0, req_ready=1. Accept = req_valid & req_ready.
- Legality:
  - b/bu: any address.
  - h/hu: addr[0]=0.
  - w: addr[1:0]=0.
  - Stores: only funct3 000/001/010 are legal.
  - Any other funct3 is illegal.
  - Illegal request: no array write; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Store (legal):
  - Byte-lane write enables: sb -> lane addr[1:0]; sh -> lanes addr[1]*2 and +1; sw -> all four lanes.
  - Data is replicated so wdata[7:0] lands in the selected byte lane, and [15:0] in the selected half.
  - Write occurs on the accept edge; unselected lanes are unchanged.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Load (legal):
  - Word is read combinationally at the accept cycle.
  - Lane is selected by addr[1:0] and extended: b/h sign-extend, bu/hu zero-extend.
  - Result is registered into rsp_rdata; rsp_valid=1 next cycle. Latency 1.
- Back-to-back: one request accepted per cycle in IDLE, no bubbles.
  - A load accepted the cycle after a store to the same word returns the stored data, because the write has committed at the earlier edge.
- rsp_valid is 0 in any cycle not following an accept. rsp_rdata/rsp_err hold their last value when rsp_valid=0.
- Address wrap: word index uses addr[ADDR_W+1:2] only; no out-of-range error.

Test Plan:
- Reset, then CLEAR_ON_RESET=1, ADDR_W=4: busy=1 for exactly 16 cycles, req_ready=0 during it. Then lw of every word -> rsp_rdata=0, rsp_err=0.
- sw 0x80FF7F01 @0x8, then lb @0x8 -> 0x00000001; lb @0x9 -> 0x0000007F; lb @0xA -> 0xFFFFFFFF; lbu @0xA -> 0x000000FF; lh @0xA -> 0xFFFF80FF; lhu @0xA -> 0x000080FF.
- After the sw above: sb 0xAB @0x9, then lw @0x8 -> 0x80FFAB01. sh 0x1234 @0xA, then lw @0x8 -> 0x1234AB01. Each load issued the cycle after its store, no stall.
- lw @0x6, lh @0x3, sw @0x2, funct3=011 load @0x0 -> each returns rsp_valid=1, rsp_err=1, rsp_rdata=0. A following lw @0x0 shows word 0 unchanged.
- Assert rstn=0 for 1 cycle mid-CLEAR (cycle 7) -> busy stays high a further 16 full cycles; no rsp_valid during CLEAR even with req_valid held high.
- Continuous req_valid stream of 8 alternating sw/lw to the same word with varying data -> 8 rsp_valid pulses on consecutive cycles; each lw returns the data from the immediately preceding sw.
